vesp_boot_sequencer: RTL and testbench
======================================

Name: vesp_boot_sequencer

Overview:
Parametrised boot controller that replaces hand-coded memory flush and program loading with synthesizable sequential hardware. It sits between the top level and the vesp CPU/memory pair. On start it performs these steps in order:
- zeroes a configurable span of main memory;
- accepts a program image over a valid/ready stream and writes it to memory;
- holds the CPU in reset for a configurable number of cycles, then releases it.

It adds address-range checking and re-boot from a running state.

Parameters:
WORD_SIZE, 16, memory word width in bits
ADDRESS_SIZE, 12, memory address width in bits
FLUSH_DEPTH, 256, number of words zeroed from address 0; must be at least 1 and at most 2**ADDRESS_SIZE
RESET_HOLD, 4, cycles the CPU reset stays asserted after loading ends; must be at least 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  single-cycle boot request
ld_valid  input  1  load-stream word valid
ld_ready  output  1  load-stream ready
ld_addr  input  ADDRESS_SIZE  target address of the load word
ld_data  input  WORD_SIZE  load word data
ld_last  input  1  marks the final word of the image
mem_we  output  1  memory write enable
mem_addr  output  ADDRESS_SIZE  memory write address
mem_wdata  output  WORD_SIZE  memory write data
cpu_rst  output  1  CPU reset, active-low
busy  output  1  high in FLUSH, LOAD and HOLD
done  output  1  high in RUN
err  output  1  sticky out-of-range load flag

Behaviour:
- All outputs are registered.
- Reset is asynchronous and active-low on rst. While rst=0, and in the first cycle after it deasserts:
  - state=IDLE;
  - mem_we=0, mem_addr=0, mem_wdata=0;
  - cpu_rst=0, ld_ready=0, busy=0, done=0, err=0;
  - flush counter=0, hold counter=0.
- Asserting rst in any state aborts the sequence immediately. No partial write is issued after assertion.
- States are IDLE, FLUSH, LOAD, HOLD and RUN. cpu_rst=0 in every state except RUN.
- IDLE:
  - start=1 moves to FLUSH next cycle, clears err and sets busy.
  - Otherwise the sequencer stays in IDLE.
- FLUSH:
  - Each cycle drives mem_we=1, mem_addr=counter, mem_wdata=0.
  - The counter runs 0 to FLUSH_DEPTH-1, exactly FLUSH_DEPTH write cycles with no gaps.
  - After the write to FLUSH_DEPTH-1 the next state is LOAD.
  - mem_we drops to 0 that cycle unless a load write follows.
- LOAD:
  - ld_ready=1 throughout.
  - A handshake occurs when ld_valid and ld_ready are both high on a clock edge.
  - If ld_addr < FLUSH_DEPTH: the next cycle drives mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data. Latency is exactly one cycle, and back-to-back handshakes give back-to-back writes.
  - If ld_addr >= FLUSH_DEPTH: no write is issued, err is set and stays set until the next start. The word is still consumed.
  - A cycle without a handshake gives mem_we=0 in the next cycle.
  - A handshake with ld_last=1 moves to HOLD, and ld_ready drops in the same cycle the state changes. The last word's write occurs in the first HOLD cycle.
  - Later writes to an address overwrite earlier ones; there is no merge.
- HOLD:
  - Holds cpu_rst=0 for exactly RESET_HOLD cycles, counted from HOLD entry, then moves to RUN.
  - ld_ready=0 and the stream is ignored.
- RUN:
  - cpu_rst=1, done=1, busy=0, mem_we=0.
  - start=1 moves to FLUSH next cycle with cpu_rst=0, done=0 and err cleared. This is a re-boot.
- start is ignored in FLUSH, LOAD and HOLD.
- Counters use ADDRESS_SIZE+1 bits so that FLUSH_DEPTH=2**ADDRESS_SIZE terminates correctly without wrap.
- ld_data passes through unmodified. No width conversion is performed.

Test Plan:
- Reset mid-flush: with FLUSH_DEPTH=256, start, then drop rst at flush address 100.
  - Required: all outputs go to reset values asynchronously, state=IDLE, no further mem_we.
  - Then start again: the flush restarts at address 0.
- Full boot with the default parameters: start, then stream five words (2:2000, 3:1458, 4:8000, 5:D000, 6:7000, last on 6).
  - Required: 256 consecutive zero writes at addresses 0..255.
  - Then five writes with matching address and data, each one cycle after its handshake.
  - cpu_rst rises exactly 4 cycles after the last handshake; done=1 and err=0.
- Load stalls and back-to-back words: toggle ld_valid 1,0,1,1 with addresses 10,11,12.
  - Required: mem_we follows one cycle delayed with pattern 1,0,1,1.
  - Addresses and data are correct and no word is lost.
- Out-of-range load: ld_addr=300 with FLUSH_DEPTH=256, followed by an in-range last word at address 7.
  - Required: no write to 300, err=1 sticky through RUN, the write to address 7 occurs, and boot completes.
- Re-boot and ignored start: pulse start during LOAD, which must be ignored with the state unchanged. After RUN, pulse start.
  - Required: cpu_rst drops the next cycle, done=0, err is cleared, and the flush restarts at 0.
- Parameter corner: FLUSH_DEPTH=16, ADDRESS_SIZE=4, RESET_HOLD=1.
  - Required: 16 flush writes at addresses 0..15 with no wrap.
  - The LOAD state is entered, and cpu_rst rises exactly one cycle after the last handshake.

Source files
------------

// File: rtl/vesp_boot_sequencer.sv
// ---------------------------------------------------------------------------
// vesp_boot_sequencer
//
// Boot controller that sits between the top level and the vesp CPU/memory
// pair. On a start request it zeroes the low FLUSH_DEPTH words of main
// memory, then accepts a program image over a valid/ready stream and writes
// it to memory. It then holds the CPU in reset for RESET_HOLD cycles before
// releasing it. Out-of-range load addresses are dropped and flagged. A start
// request while running re-boots the system.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-low
//   start      in   single-cycle boot request (honoured in IDLE and RUN)
//   ld_valid   in   load-stream word valid
//   ld_ready   out  load-stream ready, high throughout LOAD
//   ld_addr    in   target address of the load word
//   ld_data    in   load word data
//   ld_last    in   marks the final word of the image
//   mem_we     out  memory write enable
//   mem_addr   out  memory write address
//   mem_wdata  out  memory write data
//   cpu_rst    out  CPU reset, active-low (released only in RUN)
//   busy       out  high in FLUSH, LOAD and HOLD
//   done       out  high in RUN
//   err        out  sticky out-of-range load flag, cleared by start
// ---------------------------------------------------------------------------
module vesp_boot_sequencer #(
  parameter int WORD_SIZE    = 16,
  parameter int ADDRESS_SIZE = 12,
  parameter int FLUSH_DEPTH  = 256,
  parameter int RESET_HOLD   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [ADDRESS_SIZE-1:0] ld_addr,
  input  logic [WORD_SIZE-1:0]    ld_data,
  input  logic                    ld_last,
  output logic                    mem_we,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]    mem_wdata,
  output logic                    cpu_rst,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  // One extra bit lets the flush counter reach 2**ADDRESS_SIZE without
  // wrapping back to zero when the whole address space is flushed.
  localparam int CNT_W  = ADDRESS_SIZE + 1;
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);

  localparam logic [CNT_W-1:0]  FLUSH_END = CNT_W'(FLUSH_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(RESET_HOLD);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    LOAD,
    HOLD,
    RUN
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    flush_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                handshake;
  logic                in_range;

  // A word is consumed on any edge where both sides agree; whether it is
  // written depends only on whether its address lies inside the flushed span.
  assign handshake = ld_valid & ld_ready;
  assign in_range  = {1'b0, ld_addr} < FLUSH_END;

  // Boot state machine. Every output is a register updated here, so each
  // state's outputs are set up on the edge that enters the state. mem_we
  // defaults low and is raised only on edges that schedule a write.
  //
  // flush_cnt holds the address of the NEXT flush write: the write to
  // address 0 is issued on the start edge itself so that every FLUSH cycle
  // carries a write, and flushing ends once the counter reaches FLUSH_DEPTH.
  //
  // hold_cnt counts HOLD cycles already elapsed, starting at 1 on the edge
  // of the last handshake, so RUN is entered exactly RESET_HOLD edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b0;
      ld_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      flush_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (start) begin
            state     <= FLUSH;
            busy      <= 1'b1;
            done      <= 1'b0;
            cpu_rst   <= 1'b0;
            err       <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            flush_cnt <= CNT_W'(1);
          end
        end

        FLUSH: begin
          if (flush_cnt == FLUSH_END) begin
            state    <= LOAD;
            ld_ready <= 1'b1;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= flush_cnt[ADDRESS_SIZE-1:0];
            mem_wdata <= '0;
            flush_cnt <= flush_cnt + CNT_W'(1);
          end
        end

        LOAD: begin
          if (handshake) begin
            if (in_range) begin
              mem_we    <= 1'b1;
              mem_addr  <= ld_addr;
              mem_wdata <= ld_data;
            end else begin
              err <= 1'b1;
            end
            if (ld_last) begin
              state    <= HOLD;
              ld_ready <= 1'b0;
              hold_cnt <= HOLD_W'(1);
            end
          end
        end

        HOLD: begin
          if (hold_cnt == HOLD_END) begin
            state   <= RUN;
            cpu_rst <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vesp_boot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vesp_boot_sequencer
//
// Drives two sequencers: instance A with the default parameters and instance
// B with the small corner configuration (16-word flush, 4-bit addresses,
// one-cycle reset hold). Expected behaviour is kept as a timeline per
// instance: the cycle the boot started, the cycle loading opens and closes,
// the cycle RUN begins, the cycle err was raised, and a table of expected
// memory writes keyed by cycle. Outputs are sampled on the falling edge and
// compared every cycle against that timeline.
// ---------------------------------------------------------------------------
module tb_vesp_boot_sequencer;

  localparam int NONE = 32'h3fff_ffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  start;
  logic [1:0]  ldValid;
  logic [1:0]  ldLast;
  logic [11:0] ldAddrA;
  logic [15:0] ldDataA;
  logic [3:0]  ldAddrB;
  logic [15:0] ldDataB;

  wire         weA, readyA, cpuRstA, busyA, doneA, errA;
  wire  [11:0] memAddrA;
  wire  [15:0] memWdataA;
  wire         weB, readyB, cpuRstB, busyB, doneB, errB;
  wire  [3:0]  memAddrB;
  wire  [15:0] memWdataB;

  vesp_boot_sequencer dutA (
    .clk       (clk),
    .rst       (rst),
    .start     (start[0]),
    .ld_valid  (ldValid[0]),
    .ld_ready  (readyA),
    .ld_addr   (ldAddrA),
    .ld_data   (ldDataA),
    .ld_last   (ldLast[0]),
    .mem_we    (weA),
    .mem_addr  (memAddrA),
    .mem_wdata (memWdataA),
    .cpu_rst   (cpuRstA),
    .busy      (busyA),
    .done      (doneA),
    .err       (errA)
  );

  vesp_boot_sequencer #(
    .WORD_SIZE    (16),
    .ADDRESS_SIZE (4),
    .FLUSH_DEPTH  (16),
    .RESET_HOLD   (1)
  ) dutB (
    .clk       (clk),
    .rst       (rst),
    .start     (start[1]),
    .ld_valid  (ldValid[1]),
    .ld_ready  (readyB),
    .ld_addr   (ldAddrB),
    .ld_data   (ldDataB),
    .ld_last   (ldLast[1]),
    .mem_we    (weB),
    .mem_addr  (memAddrB),
    .mem_wdata (memWdataB),
    .cpu_rst   (cpuRstB),
    .busy      (busyB),
    .done      (doneB),
    .err       (errB)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  bit monOn       = 1'b0;

  // Timeline of the current boot per instance (index 0 = A, 1 = B).
  int fd[2] = '{256, 16};
  int rh[2] = '{4, 1};
  int bootS[2];
  int loadS[2];
  int loadEnd[2];
  int runAt[2];
  int errAt[2];
  logic [11:0] expAddr[int];
  logic [15:0] expData[int];

  // Rising-edge counter: at a falling edge, cyc equals the number of rising
  // edges seen so far, i.e. the edge whose results are currently visible.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, want);
    end
  endtask

  function automatic bit expBusy(int u, int c);
    return (c >= bootS[u]) && (c < runAt[u]);
  endfunction

  function automatic bit expDone(int u, int c);
    return c >= runAt[u];
  endfunction

  function automatic bit expReady(int u, int c);
    return (c >= loadS[u]) && (c < loadEnd[u]);
  endfunction

  function automatic bit expErr(int u, int c);
    return c >= errAt[u];
  endfunction

  task automatic clearModel();
    for (int u = 0; u < 2; u++) begin
      bootS[u]   = NONE;
      loadS[u]   = NONE;
      loadEnd[u] = NONE;
      runAt[u]   = NONE;
      errAt[u]   = NONE;
    end
    expAddr.delete();
    expData.delete();
  endtask

  // Compares one instance's visible outputs against the timeline.
  task automatic checkDut(input int u);
    logic        we, bz, dn, cr, rd, er;
    logic [11:0] a;
    logic [15:0] d;
    string       p;
    int          k;
    bit          w;
    if (u == 0) begin
      we = weA; a = memAddrA; d = memWdataA;
      bz = busyA; dn = doneA; cr = cpuRstA; rd = readyA; er = errA;
      p = "A ";
    end else begin
      we = weB; a = {8'h00, memAddrB}; d = memWdataB;
      bz = busyB; dn = doneB; cr = cpuRstB; rd = readyB; er = errB;
      p = "B ";
    end
    k = cyc * 2 + u;
    w = expAddr.exists(k);
    checkOutput({p, "mem_we"}, 32'(we), 32'(w));
    if (w) begin
      checkOutput({p, "mem_addr"}, 32'(a), 32'(expAddr[k]));
      checkOutput({p, "mem_wdata"}, 32'(d), 32'(expData[k]));
    end
    checkOutput({p, "busy"}, 32'(bz), 32'(expBusy(u, cyc)));
    checkOutput({p, "done"}, 32'(dn), 32'(expDone(u, cyc)));
    checkOutput({p, "cpu_rst"}, 32'(cr), 32'(expDone(u, cyc)));
    checkOutput({p, "ld_ready"}, 32'(rd), 32'(expReady(u, cyc)));
    checkOutput({p, "err"}, 32'(er), 32'(expErr(u, cyc)));
  endtask

  // Per-cycle monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (monOn) begin
      checkDut(0);
      checkDut(1);
    end
  end

  task automatic checkResetValues();
    checkOutput("rst A mem_we", 32'(weA), 32'd0);
    checkOutput("rst A mem_addr", 32'(memAddrA), 32'd0);
    checkOutput("rst A mem_wdata", 32'(memWdataA), 32'd0);
    checkOutput("rst A cpu_rst", 32'(cpuRstA), 32'd0);
    checkOutput("rst A ld_ready", 32'(readyA), 32'd0);
    checkOutput("rst A busy", 32'(busyA), 32'd0);
    checkOutput("rst A done", 32'(doneA), 32'd0);
    checkOutput("rst A err", 32'(errA), 32'd0);
    checkOutput("rst B mem_we", 32'(weB), 32'd0);
    checkOutput("rst B cpu_rst", 32'(cpuRstB), 32'd0);
    checkOutput("rst B busy", 32'(busyB), 32'd0);
    checkOutput("rst B done", 32'(doneB), 32'd0);
  endtask

  // Drives one cycle of inputs on instance u and records what that cycle's
  // rising edge should cause. hs reports whether a word is consumed.
  task automatic applyStimulus(input int u, input bit st, input bit v,
                               input logic [11:0] a, input logic [15:0] d,
                               input bit l, output bit hs);
    int n;
    int h;
    @(negedge clk);
    #1;
    n = cyc;
    start   = '0;
    ldValid = '0;
    ldLast  = '0;
    start[u]   = st;
    ldValid[u] = v;
    ldLast[u]  = l;
    if (u == 0) begin
      ldAddrA = a;
      ldDataA = d;
    end else begin
      ldAddrB = a[3:0];
      ldDataB = d;
    end
    hs = v && expReady(u, n);
    h  = n + 1;
    if (st && ((bootS[u] == NONE) || (n >= runAt[u]))) begin
      bootS[u]   = h;
      loadS[u]   = h + fd[u];
      loadEnd[u] = NONE;
      runAt[u]   = NONE;
      errAt[u]   = NONE;
      for (int k = 0; k < fd[u]; k++) begin
        expAddr[(h + k) * 2 + u] = 12'(k);
        expData[(h + k) * 2 + u] = 16'h0000;
      end
    end
    if (hs) begin
      if (int'(a) < fd[u]) begin
        expAddr[h * 2 + u] = a;
        expData[h * 2 + u] = d;
      end else if (errAt[u] == NONE) begin
        errAt[u] = h;
      end
      if (l) begin
        loadEnd[u] = h;
        runAt[u]   = h + rh[u];
      end
    end
  endtask

  task automatic idle(input int u, input int n);
    bit hs;
    repeat (n) applyStimulus(u, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, hs);
  endtask

  // Holds a word on the stream until it is accepted (bounded).
  task automatic sendWord(input int u, input logic [11:0] a,
                          input logic [15:0] d, input bit l);
    bit hs = 1'b0;
    int tries = 0;
    while (!hs && tries < 1000) begin
      applyStimulus(u, 1'b0, 1'b1, a, d, l, hs);
      tries++;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    #1;
    rst     = 1'b0;
    start   = '0;
    ldValid = '0;
    ldLast  = '0;
    clearModel();
    #1;
    checkResetValues();
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic randomBoot(input int u, input int maxWords, input int addrMax);
    bit hs;
    int nWords;
    applyStimulus(u, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, hs);
    nWords = $urandom_range(maxWords, 1);
    for (int i = 0; i < nWords; i++) begin
      repeat ($urandom_range(2, 0))
        applyStimulus(u, 1'($urandom_range(1, 0)), 1'b0, 12'h000, 16'h0000, 1'b0, hs);
      sendWord(u, 12'($urandom_range(addrMax, 0)), 16'($urandom), i == nWords - 1);
    end
    idle(u, rh[u] + 3);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    bit hs;
    rst     = 1'b0;
    start   = '0;
    ldValid = '0;
    ldLast  = '0;
    ldAddrA = '0;
    ldDataA = '0;
    ldAddrB = '0;
    ldDataB = '0;
    clearModel();
    #12;
    checkResetValues();
    @(negedge clk);
    #1;
    rst   = 1'b1;
    monOn = 1'b1;
    idle(0, 2);

    $display("[TB] reset in the middle of a flush");
    applyStimulus(0, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, hs);
    t = bootS[0] + 100;
    while (cyc < t - 1) idle(0, 1);
    applyReset();
    idle(0, 4);

    $display("[TB] full boot with the five-word image");
    applyStimulus(0, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, hs);
    sendWord(0, 12'd2, 16'h2000, 1'b0);
    sendWord(0, 12'd3, 16'h1458, 1'b0);
    sendWord(0, 12'd4, 16'h8000, 1'b0);
    sendWord(0, 12'd5, 16'hD000, 1'b0);
    sendWord(0, 12'd6, 16'h7000, 1'b1);
    idle(0, 8);

    $display("[TB] re-boot, stalls, ignored start and out-of-range word");
    applyStimulus(0, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, hs);
    sendWord(0, 12'd10, 16'hA010, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, hs);
    sendWord(0, 12'd11, 16'hA011, 1'b0);
    sendWord(0, 12'd12, 16'hA012, 1'b0);
    sendWord(0, 12'd300, 16'hBAD0, 1'b0);
    sendWord(0, 12'd7, 16'h0777, 1'b1);
    idle(0, 10);

    $display("[TB] randomized boots on the default configuration");
    for (int i = 0; i < 4; i++) randomBoot(0, 6, 299);

    $display("[TB] randomized boots on the small configuration");
    for (int i = 0; i < 4; i++) randomBoot(1, 4, 15);

    applyStimulus(0, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, hs);
    idle(0, 5);
    monOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
